wb_trace_buffer: RTL

Parametrised capture buffer that records retirement events from the MIPS pipeline: register writebacks and data-memory stores, each tagged with PC and a cycle stamp. It sits beside the pipeline top, on the writeback/store signals, and replaces waveform inspection for checking program execution. Benches and a debug readout drain it through a pop interface. It supports stop-when-full or circular-overwrite mode, a register-0 filter, and drop accounting.

---
 rtl/wb_trace_buffer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: capture FIFO for pipeline retirement events.
//   Records one entry per cycle in which a qualified register writeback
//   (wb_reg != 0) and/or a data-memory store retires, tagged with PC and a
//   free-running cycle stamp. Drained oldest-first through rd_en / rd_*.
// Ports:
//   clk, reset (async, active-high), en (capture enable), clear (sync flush)
//   pc, wb_valid/wb_reg/wb_data, st_valid/st_addr/st_data : event inputs
//   rd_en -> rd_valid + rd_kind/rd_pc/rd_wb_reg/rd_wb_data/rd_st_addr/
//            rd_st_data/rd_cyc one cycle later
//   count, empty, full : registered occupancy
//   overflow (sticky), drop_cnt (saturating) : lost-event accounting
module wb_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 6,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16,
  parameter int WRAP   = 0,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          pc,
  input  logic                       wb_valid,
  input  logic [REG_W-1:0]           wb_reg,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       st_valid,
  input  logic [DATA_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [1:0]                 rd_kind,
  output logic [DATA_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]          rd_wb_data,
  output logic [DATA_W-1:0]          rd_st_addr,
  output logic [DATA_W-1:0]          rd_st_data,
  output logic [REG_W-1:0]           rd_wb_reg,
  output logic [CYC_W-1:0]           rd_cyc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam bit WRAP_EN = (WRAP != 0);

  typedef struct packed {
    logic [1:0]        kind;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [CYC_W-1:0]  cyc;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          cap, rd_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CYC_W-1:0] cyc;
  logic [CW-1:0]   count_nxt;
  logic            wbq, stq, push, pop, do_write, drop, inc, dec;

  assign wbq  = wb_valid && (wb_reg != '0);
  assign stq  = st_valid;
  assign push = en && (wbq || stq) && !clear;
  assign pop  = rd_en && !empty && !clear;

  // When full, a same-cycle pop frees the slot so the push lands without loss.
  // Without a pop, WRAP overwrites the oldest slot (wr_ptr == rd_ptr when full).
  assign drop     = push && full && !pop;
  assign do_write = push && (!full || pop || WRAP_EN);
  assign inc      = do_write && !pop && !full;
  assign dec      = pop && !do_write;

  always_comb begin
    cap.kind    = {stq, wbq};
    cap.pc      = pc;
    cap.wb_reg  = wbq ? wb_reg  : '0;
    cap.wb_data = wbq ? wb_data : '0;
    cap.st_addr = stq ? st_addr : '0;
    cap.st_data = stq ? st_data : '0;
    cap.cyc     = cyc;
  end

  always_comb begin
    count_nxt = count;
    if (inc)      count_nxt = count + CW'(1);
    else if (dec) count_nxt = count - CW'(1);
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= cap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      cyc      <= '0;
      rd_valid <= 1'b0;
      rd_q     <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      cyc      <= '0;
      rd_valid <= 1'b0;
    end else begin
      cyc      <= cyc + CYC_W'(1);
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == CW'(DEPTH));
      rd_valid <= pop;
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (pop || (drop && WRAP_EN)) rd_ptr <= rd_ptr + AW'(1);
      if (pop) rd_q <= mem[rd_ptr];
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  assign rd_kind    = rd_q.kind;
  assign rd_pc      = rd_q.pc;
  assign rd_wb_reg  = rd_q.wb_reg;
  assign rd_wb_data = rd_q.wb_data;
  assign rd_st_addr = rd_q.st_addr;
  assign rd_st_data = rd_q.st_data;
  assign rd_cyc     = rd_q.cyc;

endmodule
